// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared types and constants for the TLB management unit
// Entry layout, op encodings and CSR field positions shared with the TLB array and CSR file.
package tlb_pkg;

    localparam int ENTRY_W = 89;

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } tlb_state_e;

    localparam logic [5:0] PS_4K      = 6'd12;
    localparam logic [5:0] PS_2M      = 6'd21;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [4:0] INVOP_MAX  = 5'd6;

    localparam int TLBIDX_NE     = 31;
    localparam int TLBIDX_PS_MSB = 29;
    localparam int TLBIDX_PS_LSB = 24;

    localparam int ELO_V       = 0;
    localparam int ELO_D       = 1;
    localparam int ELO_PLV_LSB = 2;
    localparam int ELO_MAT_LSB = 4;
    localparam int ELO_G       = 6;
    localparam int ELO_PPN_LSB = 8;

    // Packed MSB-first: e[88], vppn[87:69], ps[68:63], asid[62:53], g[52], page0[51:26], page1[25:0]
    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        tlb_page_t   p0;
        tlb_page_t   p1;
    } tlb_entry_t;

    function automatic logic [31:0] page_to_elo(input tlb_page_t p, input logic g);
        return {4'b0, p.ppn, 1'b0, g, p.mat, p.plv, p.d, p.v};
    endfunction

endpackage

// File: rtl/tlb_op_unit_if.sv
// rtl/tlb_op_unit_if.sv - WB stage / CSR file side of the TLB management unit
// Carries the command handshake, live CSR values and the CSR update response.
interface tlb_op_unit_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_invop;
    logic [9:0]  cmd_inv_asid;
    logic [31:0] cmd_inv_va;
    logic        cmd_flush;

    logic [31:0] csr_tlbidx;
    logic [18:0] csr_tlbehi;
    logic [31:0] csr_tlbelo0;
    logic [31:0] csr_tlbelo1;
    logic [9:0]  csr_asid;
    logic [5:0]  csr_ecode;

    logic        rsp_valid;
    logic        rsp_ine;
    logic        upd_tlbidx_we;
    logic        upd_entry_we;
    logic [31:0] upd_tlbidx;
    logic [18:0] upd_tlbehi;
    logic [31:0] upd_tlbelo0;
    logic [31:0] upd_tlbelo1;
    logic [9:0]  upd_asid;

    modport master (
        output cmd_valid, cmd_op, cmd_invop, cmd_inv_asid, cmd_inv_va, cmd_flush,
        output csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1, csr_asid, csr_ecode,
        input  cmd_ready, rsp_valid, rsp_ine, upd_tlbidx_we, upd_entry_we,
        input  upd_tlbidx, upd_tlbehi, upd_tlbelo0, upd_tlbelo1, upd_asid
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_invop, cmd_inv_asid, cmd_inv_va, cmd_flush,
        input  csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1, csr_asid, csr_ecode,
        output cmd_ready, rsp_valid, rsp_ine, upd_tlbidx_we, upd_entry_we,
        output upd_tlbidx, upd_tlbehi, upd_tlbelo0, upd_tlbelo1, upd_asid
    );

endinterface

// File: rtl/tlb_op_unit.sv
// rtl/tlb_op_unit.sv - executes TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB from writeback
// Three-state IDLE/EXEC/RESP sequencer; TLB ports are only driven during EXEC.
module tlb_op_unit
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = $clog2(TLBNUM)
) (
    input  logic               clk,
    input  logic               resetn,
    tlb_op_unit_if.slave       wb,

    output logic               tlb_s1_own,
    output logic [18:0]        tlb_s1_vppn,
    output logic               tlb_s1_va_bit12,
    output logic [9:0]         tlb_s1_asid,
    input  logic               tlb_s1_found,
    input  logic [IDX_W-1:0]   tlb_s1_index,

    output logic [IDX_W-1:0]   tlb_r_index,
    input  logic [ENTRY_W-1:0] tlb_r_entry,

    output logic               tlb_we,
    output logic [IDX_W-1:0]   tlb_w_index,
    output logic [ENTRY_W-1:0] tlb_w_entry,

    output logic               tlb_inv_valid,
    output logic [4:0]         tlb_inv_op
);

    tlb_state_e       state;
    logic [2:0]       op_q;
    logic [4:0]       invop_q;
    logic [9:0]       inv_asid_q;
    logic [19:0]      inv_va_q;
    logic [IDX_W-1:0] fill_cnt;

    logic             idx_we_q;
    logic             ent_we_q;
    logic             ine_q;
    logic [31:0]      tlbidx_q;
    logic [18:0]      ehi_q;
    logic [31:0]      elo0_q;
    logic [31:0]      elo1_q;
    logic [9:0]       asid_q;

    logic             exec;
    logic             live;
    logic             is_srch;
    logic             is_rd;
    logic             is_wr;
    logic             is_fill;
    logic             is_inv;
    logic             inv_ok;
    logic [31:0]      srch_tlbidx;
    logic [31:0]      rd_tlbidx;
    tlb_entry_t       r_entry;
    tlb_entry_t       w_entry;

    assign exec    = (state == ST_EXEC);
    // A flush in the EXEC cycle kills any side effect issued in that same cycle.
    assign live    = exec && !wb.cmd_flush;
    assign is_srch = (op_q == OP_SRCH);
    assign is_rd   = (op_q == OP_RD);
    assign is_wr   = (op_q == OP_WR);
    assign is_fill = (op_q == OP_FILL);
    assign is_inv  = (op_q == OP_INV);
    assign inv_ok  = (invop_q <= INVOP_MAX);
    assign r_entry = tlb_r_entry;

    always_comb begin
        srch_tlbidx = wb.csr_tlbidx;
        if (tlb_s1_found) begin
            srch_tlbidx[TLBIDX_NE]   = 1'b0;
            srch_tlbidx[IDX_W-1:0]   = tlb_s1_index;
        end else begin
            srch_tlbidx[TLBIDX_NE]   = 1'b1;
        end
    end

    always_comb begin
        rd_tlbidx = wb.csr_tlbidx;
        rd_tlbidx[TLBIDX_NE] = ~r_entry.e;
        rd_tlbidx[TLBIDX_PS_MSB:TLBIDX_PS_LSB] = r_entry.e ? r_entry.ps : 6'd0;
    end

    always_comb begin
        w_entry      = '0;
        // TLB refill handler writes are always valid regardless of TLBIDX.NE.
        w_entry.e    = (wb.csr_ecode == ECODE_TLBR) ? 1'b1 : ~wb.csr_tlbidx[TLBIDX_NE];
        w_entry.vppn = wb.csr_tlbehi;
        w_entry.ps   = wb.csr_tlbidx[TLBIDX_PS_MSB:TLBIDX_PS_LSB];
        w_entry.asid = wb.csr_asid;
        w_entry.g    = wb.csr_tlbelo0[ELO_G] & wb.csr_tlbelo1[ELO_G];
        w_entry.p0.ppn = wb.csr_tlbelo0[ELO_PPN_LSB+19:ELO_PPN_LSB];
        w_entry.p0.plv = wb.csr_tlbelo0[ELO_PLV_LSB+1:ELO_PLV_LSB];
        w_entry.p0.mat = wb.csr_tlbelo0[ELO_MAT_LSB+1:ELO_MAT_LSB];
        w_entry.p0.d   = wb.csr_tlbelo0[ELO_D];
        w_entry.p0.v   = wb.csr_tlbelo0[ELO_V];
        w_entry.p1.ppn = wb.csr_tlbelo1[ELO_PPN_LSB+19:ELO_PPN_LSB];
        w_entry.p1.plv = wb.csr_tlbelo1[ELO_PLV_LSB+1:ELO_PLV_LSB];
        w_entry.p1.mat = wb.csr_tlbelo1[ELO_MAT_LSB+1:ELO_MAT_LSB];
        w_entry.p1.d   = wb.csr_tlbelo1[ELO_D];
        w_entry.p1.v   = wb.csr_tlbelo1[ELO_V];
    end

    always_comb begin
        tlb_s1_own      = exec && (is_srch || (is_inv && inv_ok));
        tlb_s1_vppn     = '0;
        tlb_s1_asid     = '0;
        tlb_s1_va_bit12 = 1'b0;
        if (tlb_s1_own) begin
            tlb_s1_vppn     = is_inv ? inv_va_q[19:1] : wb.csr_tlbehi;
            tlb_s1_asid     = is_inv ? inv_asid_q     : wb.csr_asid;
            tlb_s1_va_bit12 = is_inv && inv_va_q[0];
        end
    end

    always_comb begin
        tlb_r_index   = (exec && is_rd) ? wb.csr_tlbidx[IDX_W-1:0] : '0;
        tlb_we        = live && (is_wr || is_fill);
        tlb_w_index   = '0;
        tlb_w_entry   = '0;
        if (exec && (is_wr || is_fill)) begin
            tlb_w_index = is_fill ? fill_cnt : wb.csr_tlbidx[IDX_W-1:0];
            tlb_w_entry = w_entry;
        end
        tlb_inv_valid = live && is_inv && inv_ok;
        tlb_inv_op    = (exec && is_inv) ? invop_q : 5'd0;
    end

    assign wb.cmd_ready     = (state == ST_IDLE) && !wb.cmd_flush;
    assign wb.rsp_valid     = (state == ST_RESP) && !wb.cmd_flush;
    assign wb.rsp_ine       = wb.rsp_valid && ine_q;
    assign wb.upd_tlbidx_we = wb.rsp_valid && idx_we_q;
    assign wb.upd_entry_we  = wb.rsp_valid && ent_we_q;
    assign wb.upd_tlbidx    = tlbidx_q;
    assign wb.upd_tlbehi    = ehi_q;
    assign wb.upd_tlbelo0   = elo0_q;
    assign wb.upd_tlbelo1   = elo1_q;
    assign wb.upd_asid      = asid_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            invop_q    <= '0;
            inv_asid_q <= '0;
            inv_va_q   <= '0;
            fill_cnt   <= '0;
            idx_we_q   <= 1'b0;
            ent_we_q   <= 1'b0;
            ine_q      <= 1'b0;
            tlbidx_q   <= '0;
            ehi_q      <= '0;
            elo0_q     <= '0;
            elo1_q     <= '0;
            asid_q     <= '0;
        end else begin
            fill_cnt <= (fill_cnt == IDX_W'(TLBNUM - 1)) ? '0 : fill_cnt + IDX_W'(1);
            case (state)
                ST_IDLE: begin
                    if (wb.cmd_valid && wb.cmd_ready) begin
                        op_q       <= wb.cmd_op;
                        invop_q    <= wb.cmd_invop;
                        inv_asid_q <= wb.cmd_inv_asid;
                        inv_va_q   <= wb.cmd_inv_va[31:12];
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (wb.cmd_flush) begin
                        state <= ST_IDLE;
                    end else begin
                        state    <= ST_RESP;
                        idx_we_q <= 1'b0;
                        ent_we_q <= 1'b0;
                        ine_q    <= 1'b0;
                        case (op_q)
                            OP_SRCH: begin
                                idx_we_q <= 1'b1;
                                tlbidx_q <= srch_tlbidx;
                            end
                            OP_RD: begin
                                idx_we_q <= 1'b1;
                                ent_we_q <= 1'b1;
                                tlbidx_q <= rd_tlbidx;
                                ehi_q    <= r_entry.e ? r_entry.vppn : 19'd0;
                                elo0_q   <= r_entry.e ? page_to_elo(r_entry.p0, r_entry.g) : 32'd0;
                                elo1_q   <= r_entry.e ? page_to_elo(r_entry.p1, r_entry.g) : 32'd0;
                                asid_q   <= r_entry.e ? r_entry.asid : 10'd0;
                            end
                            OP_WR, OP_FILL: ;
                            OP_INV:  ine_q <= !inv_ok;
                            default: ine_q <= 1'b1;
                        endcase
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
